// File: rtl/mandelbrot_pixel_driver.sv
// ============================================================================
// mandelbrot_pixel_driver
// ----------------------------------------------------------------------------
// Host-side initiator for the Mandelbrot accelerator's byte-serial load/start
// interface.
//
// One pixel request (Cr, Ci, max_iter) is accepted while the block is idle.
// The C words go out LSB-first, one byte per cycle, on an 8-bit bus:
//   - Ci first. Its last byte carries acc_load_ci.
//   - Then Cr. Its last byte carries acc_load_cr and acc_start together.
//   - Ci is not sent when the request asks the accelerator to keep its stored Ci.
//
// After start, acc_unbounded is ignored for SKIP_CYCLES cycles, because the
// flag is registered in the accelerator and can still show the previous
// pixel's value. Iteration cycles are then counted until the flag rises or
// the limit is reached. The outcome is held on a valid/ready result port.
//
// Parameters:
//   ITER_W       width of max_iter, the iteration counter and res_iter
//   SKIP_CYCLES  cycles after start in which acc_unbounded is ignored (0..3)
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   req_valid      pixel request valid
//   req_ready      request ready, high only when idle
//   req_cr         real part of C, passed through opaquely
//   req_ci         imaginary part of C, passed through opaquely
//   req_keep_ci    1 = skip sending Ci, accelerator reuses its stored Ci
//   req_max_iter   iteration limit, sampled on acceptance
//   res_valid      result valid, held until accepted
//   res_ready      result consumer ready
//   res_iter       iteration count
//   res_escaped    1 = unbounded detected, 0 = limit reached
//   acc_data       byte to the accelerator data bus
//   acc_load_cr    load-Cr strobe, on the last Cr byte
//   acc_load_ci    load-Ci strobe, on the last Ci byte
//   acc_start      start strobe, on the last Cr byte
//   acc_unbounded  registered unbounded flag from the accelerator
// ============================================================================
module mandelbrot_pixel_driver #(
  parameter int ITER_W      = 16,
  parameter int SKIP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_cr,
  input  logic [31:0]       req_ci,
  input  logic              req_keep_ci,
  input  logic [ITER_W-1:0] req_max_iter,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ITER_W-1:0] res_iter,
  output logic              res_escaped,
  output logic [7:0]        acc_data,
  output logic              acc_load_cr,
  output logic              acc_load_ci,
  output logic              acc_start,
  input  logic              acc_unbounded
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND_CI = 3'd1;
  localparam logic [2:0] ST_SEND_CR = 3'd2;
  localparam logic [2:0] ST_SKIP    = 3'd3;
  localparam logic [2:0] ST_ITERATE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Index of the last SKIP cycle. When SKIP_CYCLES is 0 the SKIP state is
  // never entered, so the value is unused in that case.
  localparam logic [1:0] SKIP_LAST = (SKIP_CYCLES > 0) ? 2'(SKIP_CYCLES - 1) : 2'd0;

  localparam logic [ITER_W-1:0] CNT_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q,       state_d;
  logic [1:0]        byte_idx_q,    byte_idx_d;
  logic [1:0]        skip_cnt_q,    skip_cnt_d;
  logic [31:0]       cr_q,          cr_d;
  logic [31:0]       ci_q,          ci_d;
  logic [ITER_W-1:0] max_iter_q,    max_iter_d;
  logic [ITER_W-1:0] cnt_q,         cnt_d;
  logic [ITER_W-1:0] res_iter_q,    res_iter_d;
  logic              res_escaped_q, res_escaped_d;

  // Byte k of a word, with byte 0 being the least significant.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Next-state and datapath logic.
  // Request fields are captured only on acceptance, and the counters are
  // cleared at the same time. Afterwards, later activity on the request
  // inputs cannot affect the pixel in flight.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    skip_cnt_d    = skip_cnt_q;
    cr_d          = cr_q;
    ci_d          = ci_q;
    max_iter_d    = max_iter_q;
    cnt_d         = cnt_q;
    res_iter_d    = res_iter_q;
    res_escaped_d = res_escaped_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cr_d       = req_cr;
          ci_d       = req_ci;
          max_iter_d = req_max_iter;
          byte_idx_d = 2'd0;
          skip_cnt_d = 2'd0;
          cnt_d      = '0;
          state_d    = req_keep_ci ? ST_SEND_CR : ST_SEND_CI;
        end
      end

      // The byte index wraps from 3 to 0. Cr therefore starts at byte 0
      // with no gap after the last Ci byte.
      ST_SEND_CI: begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          state_d = ST_SEND_CR;
        end
      end

      ST_SEND_CR: begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          state_d = (SKIP_CYCLES == 0) ? ST_ITERATE : ST_SKIP;
        end
      end

      ST_SKIP: begin
        if (skip_cnt_q == SKIP_LAST) begin
          state_d = ST_ITERATE;
        end else begin
          skip_cnt_d = skip_cnt_q + 2'd1;
        end
      end

      // Escape has priority over the limit. The counter advances only while
      // it is below max_iter, so it can never wrap.
      ST_ITERATE: begin
        if (acc_unbounded) begin
          res_iter_d    = cnt_q;
          res_escaped_d = 1'b1;
          state_d       = ST_DONE;
        end else if (cnt_q == max_iter_q) begin
          res_iter_d    = max_iter_q;
          res_escaped_d = 1'b0;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset abandons any pixel in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_idx_q    <= 2'd0;
      skip_cnt_q    <= 2'd0;
      cr_q          <= 32'd0;
      ci_q          <= 32'd0;
      max_iter_q    <= '0;
      cnt_q         <= '0;
      res_iter_q    <= '0;
      res_escaped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      skip_cnt_q    <= skip_cnt_d;
      cr_q          <= cr_d;
      ci_q          <= ci_d;
      max_iter_q    <= max_iter_d;
      cnt_q         <= cnt_d;
      res_iter_q    <= res_iter_d;
      res_escaped_q <= res_escaped_d;
    end
  end

  // Accelerator bus, decoded from the state alone. An asynchronous reset
  // forces the state to IDLE, so the bus and strobes drop at once.
  always_comb begin
    acc_data    = 8'd0;
    acc_load_ci = 1'b0;
    acc_load_cr = 1'b0;
    acc_start   = 1'b0;
    if (state_q == ST_SEND_CI) begin
      acc_data    = pick_byte(ci_q, byte_idx_q);
      acc_load_ci = (byte_idx_q == 2'd3);
    end else if (state_q == ST_SEND_CR) begin
      acc_data    = pick_byte(cr_q, byte_idx_q);
      acc_load_cr = (byte_idx_q == 2'd3);
      acc_start   = (byte_idx_q == 2'd3);
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign res_iter    = res_iter_q;
  assign res_escaped = res_escaped_q;

endmodule

// File: tb/tb_mandelbrot_pixel_driver.sv
// ============================================================================
// tb_mandelbrot_pixel_driver
// ----------------------------------------------------------------------------
// Directed, self-checking bench for mandelbrot_pixel_driver (ITER_W=16,
// SKIP_CYCLES=1).
//
// Inputs are driven and outputs are sampled on the falling clock edge. The
// rising-edge acceptance is the reference point. The n-th falling edge after
// it is called cycle n, and cycle n shows the state after n-1 further rising
// edges.
// ============================================================================
module tb_mandelbrot_pixel_driver;

  localparam int ITER_W = 16;
  localparam int LIMIT  = 300;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_cr;
  logic [31:0]       req_ci;
  logic              req_keep_ci;
  logic [ITER_W-1:0] req_max_iter;
  logic              res_valid;
  logic              res_ready;
  logic [ITER_W-1:0] res_iter;
  logic              res_escaped;
  logic [7:0]        acc_data;
  logic              acc_load_cr;
  logic              acc_load_ci;
  logic              acc_start;
  logic              acc_unbounded;

  int total = 0;
  int bad   = 0;

  mandelbrot_pixel_driver #(.ITER_W(ITER_W), .SKIP_CYCLES(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cr       (req_cr),
    .req_ci       (req_ci),
    .req_keep_ci  (req_keep_ci),
    .req_max_iter (req_max_iter),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_iter     (res_iter),
    .res_escaped  (res_escaped),
    .acc_data     (acc_data),
    .acc_load_cr  (acc_load_cr),
    .acc_load_ci  (acc_load_ci),
    .acc_start    (acc_start),
    .acc_unbounded(acc_unbounded)
  );

  always #5 clk = ~clk;

  // Present a request on a falling edge and hold it through the rising edge
  // that accepts it. Afterwards the request pins carry junk values, so that
  // any use of them after acceptance shows up in the results.
  task automatic send_request(input logic [31:0] cr, input logic [31:0] ci,
                              input logic keep, input logic [ITER_W-1:0] mi);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_ready_before_accept got=%b want=1", req_ready);
    end
    req_cr       = cr;
    req_ci       = ci;
    req_keep_ci  = keep;
    req_max_iter = mi;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_cr       = 32'hDEADBEEF;
    req_ci       = 32'hCAFEF00D;
    req_keep_ci  = ~keep;
    req_max_iter = 16'hFFFF;
  endtask

  // Wait, within a fixed budget, for res_valid. The argument c is the cycle
  // number already reached on entry and is returned as the first cycle in
  // which res_valid is high.
  task automatic wait_result(inout int c);
    while (res_valid !== 1'b1 && c < LIMIT) begin
      @(negedge clk);
      c++;
    end
    if (res_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL result_timeout got=no res_valid within %0d cycles", LIMIT);
    end
  endtask

  // Complete the result handshake. req_ready must be high in the next cycle.
  task automatic accept_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL after_handshake got req_ready=%b res_valid=%b want 1/0", req_ready, res_valid);
    end
  endtask

  task automatic check_result(input string name, input int c, input int want_c,
                              input logic [ITER_W-1:0] want_iter, input logic want_esc);
    total++;
    if (c !== want_c) begin
      bad++;
      $display("FAIL %s_latency got=cycle %0d want=cycle %0d", name, c, want_c);
    end
    total++;
    if (res_iter !== want_iter || res_escaped !== want_esc) begin
      bad++;
      $display("FAIL %s_result got iter=%0d esc=%b want iter=%0d esc=%b",
               name, res_iter, res_escaped, want_iter, want_esc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || acc_data !== 8'h00 ||
        acc_load_cr !== 1'b0 || acc_load_ci !== 1'b0 || acc_start !== 1'b0 ||
        res_iter !== 16'd0 || res_escaped !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h lcr=%b lci=%b st=%b iter=%0d esc=%b",
               req_ready, res_valid, acc_data, acc_load_cr, acc_load_ci, acc_start,
               res_iter, res_escaped);
    end
    rst = 1'b0;
  endtask

  // Full send: Ci 0x44332211 then Cr 0x88776655, max_iter=3.
  // Expected latency is 8+1+(3+1) = 13 edges, so the result appears in cycle 14.
  task automatic test_full_stream();
    logic [7:0] exp_bytes [8];
    int c;
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_request(32'h88776655, 32'h44332211, 1'b0, 16'd3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      total++;
      if (acc_data !== ((k <= 8) ? exp_bytes[k-1] : 8'h00) ||
          acc_load_ci !== (k == 4) || acc_load_cr !== (k == 8) || acc_start !== (k == 8)) begin
        bad++;
        $display("FAIL full_stream_cycle%0d got data=%h lci=%b lcr=%b st=%b", k,
                 acc_data, acc_load_ci, acc_load_cr, acc_start);
      end
    end
    c = 9;
    wait_result(c);
    check_result("full_stream", c, 14, 16'd3, 1'b0);
    accept_result();
  endtask

  // keep_ci=1 with Cr 0x12345678 and max_iter=4.
  // Expected latency is 4+1+5 = 10 edges, so the result appears in cycle 11.
  task automatic test_keep_ci();
    logic [7:0] exp_bytes [4];
    int c;
    exp_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    send_request(32'h12345678, 32'hFFFFFFFF, 1'b1, 16'd4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (acc_data !== ((k <= 4) ? exp_bytes[k-1] : 8'h00) || acc_load_ci !== 1'b0 ||
          acc_load_cr !== (k == 4) || acc_start !== (k == 4)) begin
        bad++;
        $display("FAIL keep_ci_cycle%0d got data=%h lci=%b lcr=%b st=%b", k,
                 acc_data, acc_load_ci, acc_load_cr, acc_start);
      end
    end
    c = 5;
    wait_result(c);
    check_result("keep_ci", c, 11, 16'd4, 1'b0);
    accept_result();
  endtask

  // Iteration limits. max_iter=100 gives 8+1+101 = 110 edges, result in
  // cycle 111. max_iter=0 gives 8+1+1 = 10 edges, result in cycle 11.
  task automatic test_limit();
    int c;
    acc_unbounded = 1'b0;
    send_request(32'h00010002, 32'h00030004, 1'b0, 16'd100);
    c = 0;
    wait_result(c);
    check_result("limit100", c, 111, 16'd100, 1'b0);
    accept_result();
    send_request(32'h00050006, 32'h00070008, 1'b0, 16'd0);
    c = 0;
    wait_result(c);
    check_result("limit0", c, 11, 16'd0, 1'b0);
    accept_result();
  endtask

  // acc_unbounded is high while SEND_CR ends and through SKIP (sampled at
  // the ends of cycles 8 and 9). It is low for ITERATE cnt 0..4 (cycles
  // 10..14) and high again at cnt=5 (cycle 15). The expected result is
  // res_iter=5 with escape, first visible in cycle 16.
  task automatic test_escape();
    int c;
    int found;
    send_request(32'h11112222, 32'h33334444, 1'b0, 16'd100);
    c = 0;
    found = 0;
    while (found == 0 && c < 60) begin
      @(negedge clk);
      c++;
      if (res_valid === 1'b1) begin
        found = c;
      end else if (c == 8) begin
        acc_unbounded = 1'b1;
      end else if (c == 10) begin
        acc_unbounded = 1'b0;
      end else if (c == 15) begin
        acc_unbounded = 1'b1;
      end
    end
    acc_unbounded = 1'b0;
    check_result("escape", found, 16, 16'd5, 1'b1);
    accept_result();
  endtask

  // Result back-pressure, followed by a back-to-back request.
  // keep_ci=1 and max_iter=2 give 4+1+3 = 8 edges, result in cycle 9.
  task automatic test_back_to_back();
    int c;
    send_request(32'hAAAA5555, 32'h0, 1'b1, 16'd2);
    c = 0;
    wait_result(c);
    check_result("backpressure", c, 9, 16'd2, 1'b0);
    // This request is ignored while a result is pending.
    req_valid    = 1'b1;
    req_keep_ci  = 1'b1;
    req_cr       = 32'hA1B2C3D4;
    req_max_iter = 16'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_iter !== 16'd2 || res_escaped !== 1'b0 ||
          req_ready !== 1'b0 || acc_data !== 8'h00) begin
        bad++;
        $display("FAIL hold_cycle%0d got vld=%b iter=%0d esc=%b rdy=%b data=%h", k,
                 res_valid, res_iter, res_escaped, req_ready, acc_data);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got rdy=%b vld=%b want 1/0", req_ready, res_valid);
    end
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_cr       = 32'hDEADBEEF;
    req_max_iter = 16'hFFFF;
    @(negedge clk);
    total++;
    if (acc_data !== 8'hD4 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first_byte got data=%h rdy=%b want d4/0", acc_data, req_ready);
    end
    // max_iter=0 with keep_ci=1 gives 4+1+1 = 6 edges, result in cycle 7.
    c = 1;
    wait_result(c);
    check_result("b2b", c, 7, 16'd0, 1'b0);
    accept_result();
  endtask

  // Reset while the third Cr byte (k=2, cycle 7) is on the bus.
  task automatic test_reset_mid();
    int c;
    send_request(32'h99AABBCC, 32'h01020304, 1'b0, 16'd5);
    repeat (7) @(negedge clk);
    total++;
    if (acc_data !== 8'hAA) begin
      bad++;
      $display("FAIL pre_reset_byte got=%h want=aa", acc_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if (acc_data !== 8'h00 || acc_load_cr !== 1'b0 || acc_load_ci !== 1'b0 ||
        acc_start !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got data=%h lcr=%b lci=%b st=%b rdy=%b vld=%b",
               acc_data, acc_load_cr, acc_load_ci, acc_start, req_ready, res_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0 || acc_data !== 8'h00 || req_ready !== 1'b1) begin
        bad++;
        $display("FAIL post_reset_idle%0d got vld=%b data=%h rdy=%b", k, res_valid, acc_data, req_ready);
      end
    end
    // The follow-up request is a full send with max_iter=1:
    // 8+1+2 = 11 edges, result in cycle 12.
    send_request(32'h0BADF00D, 32'h76543210, 1'b0, 16'd1);
    @(negedge clk);
    total++;
    if (acc_data !== 8'h10) begin
      bad++;
      $display("FAIL post_reset_first_byte got=%h want=10", acc_data);
    end
    c = 1;
    wait_result(c);
    check_result("post_reset", c, 12, 16'd1, 1'b0);
    accept_result();
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_cr        = 32'd0;
    req_ci        = 32'd0;
    req_keep_ci   = 1'b0;
    req_max_iter  = '0;
    res_ready     = 1'b0;
    acc_unbounded = 1'b0;
    test_reset();
    test_full_stream();
    test_keep_ci();
    test_limit();
    test_escape();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
